async_receiver: RTL and testbench

RS-232 receive block, the counterpart to the team's 8N1 UART transmitter. It oversamples the serial line, detects and validates start bits, and deserialises 8 data bits LSB-first. It checks the stop bit and presents each byte with a one-cycle strobe. It also reports line-idle and end-of-packet gaps, so host logic can frame bursts of bytes.

---
 rtl/async_uart_pkg.sv | 23 ++
 rtl/async_receiver_if.sv | 18 +
 rtl/async_baud_tick_gen.sv | 30 +++
 rtl/async_receiver.sv | 164 ++++++++++++++++
 tb/tb_async_receiver.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/async_uart_pkg.sv
// Shared 8N1 UART definitions: receiver states, frame constants, baud accumulator increment.
package async_uart_pkg;

  localparam int DATA_BITS = 8;
  localparam int STOP_BITS = 1;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_WAIT_HIGH
  } rx_state_e;

  // Fractional accumulator step: round(baud*ovs*2^acc_w / clk_hz) in 64-bit arithmetic.
  function automatic longint unsigned baud_inc(input longint unsigned clk_hz,
                                               input longint unsigned baud,
                                               input longint unsigned ovs,
                                               input longint unsigned acc_w);
    return (((baud * ovs) << acc_w) + clk_hz / 2) / clk_hz;
  endfunction

endpackage

// File: rtl/async_receiver_if.sv
// Serial line plus received-byte/status signals between the receiver and host logic.
interface async_receiver_if;
  import async_uart_pkg::*;

  logic                 RxD;
  logic [DATA_BITS-1:0] RxD_data;
  logic                 RxD_data_ready;
  logic                 RxD_frame_error;
  logic                 RxD_idle;
  logic                 RxD_endofpacket;

  // Host / line side
  modport master (output RxD,
                  input  RxD_data, RxD_data_ready, RxD_frame_error, RxD_idle, RxD_endofpacket);
  // Receiver side
  modport slave  (input  RxD,
                  output RxD_data, RxD_data_ready, RxD_frame_error, RxD_idle, RxD_endofpacket);
endinterface

// File: rtl/async_baud_tick_gen.sv
// Fractional-N tick generator: carry out of a free-running accumulator, Rate ticks per second.
module async_baud_tick_gen
  import async_uart_pkg::*;
#(
  parameter int ClkFrequency = 25000000,
  parameter int Rate         = 115200 * 8,
  parameter int AccWidth     = 16
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);
  localparam logic [AccWidth:0] Inc =
    (AccWidth + 1)'(baud_inc(ClkFrequency, Rate, 1, AccWidth));

  logic [AccWidth:0] acc_q, acc_d;

  // Previous carry is dropped before the add, so tick lasts exactly one clk.
  always_comb begin
    acc_d = {1'b0, acc_q[AccWidth-1:0]} + Inc;
  end

  // Accumulator register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) acc_q <= '0;
    else        acc_q <= acc_d;
  end

  assign tick = acc_q[AccWidth];
endmodule

// File: rtl/async_receiver.sv
// 8N1 serial receiver: oversampled start detect, majority filter, byte strobe, idle/end-of-packet.
module async_receiver
  import async_uart_pkg::*;
#(
  parameter int ClkFrequency = 25000000,
  parameter int Baud         = 115200,
  parameter int Oversampling = 8,
  parameter int AccWidth     = 16,
  parameter int IdleBits     = 10
) (
  input  logic           clk,
  input  logic           rst_n,
  async_receiver_if.slave rx
);
  localparam int PhW    = $clog2(Oversampling);
  localparam int BitW   = $clog2(DATA_BITS);
  localparam int GapMax = Oversampling * IdleBits;
  localparam int GapW   = $clog2(GapMax + 1);

  localparam logic [PhW-1:0]  PhaseMid  = PhW'(Oversampling / 2 - 1);
  localparam logic [PhW-1:0]  PhaseLast = PhW'(Oversampling - 1);
  localparam logic [BitW-1:0] BitLast   = BitW'(DATA_BITS - 1);
  localparam logic [GapW-1:0] GapSat    = GapW'(GapMax);

  logic tick;

  async_baud_tick_gen #(
    .ClkFrequency(ClkFrequency),
    .Rate        (Baud * Oversampling),
    .AccWidth    (AccWidth)
  ) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .tick (tick)
  );

  rx_state_e            state_q, state_d;
  logic [1:0]           sync_q, sync_d;
  logic [2:0]           filt_q, filt_d;
  logic [PhW-1:0]       phase_q, phase_d;
  logic [BitW-1:0]      bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 ready_q, ready_d;
  logic                 ferr_q, ferr_d;
  logic [GapW-1:0]      gap_q, gap_d;
  logic                 seen_q, seen_d;
  logic                 eop_q, eop_d;
  logic                 rx_bit;

  // Synchroniser runs every clk; the glitch filter only samples on tick.
  always_comb begin
    sync_d = {sync_q[0], rx.RxD};
    filt_d = filt_q;
    if (tick) filt_d = {filt_q[1:0], sync_q[1]};
  end

  assign rx_bit = (filt_q[0] & filt_q[1]) | (filt_q[0] & filt_q[2]) | (filt_q[1] & filt_q[2]);

  // Next-state: START re-checks mid start bit so short glitches fall back to IDLE.
  always_comb begin
    state_d = state_q;
    if (tick) begin
      case (state_q)
        RX_IDLE:      if (!rx_bit) state_d = RX_START;
        RX_START:     if (phase_q == PhaseMid) state_d = rx_bit ? RX_IDLE : RX_DATA;
        RX_DATA:      if (phase_q == PhaseLast && bit_cnt_q == BitLast) state_d = RX_STOP;
        RX_STOP:      if (phase_q == PhaseLast) state_d = rx_bit ? RX_IDLE : RX_WAIT_HIGH;
        RX_WAIT_HIGH: if (rx_bit) state_d = RX_IDLE;
        default:      state_d = RX_IDLE;
      endcase
    end
  end

  // Datapath/outputs: phase counting, LSB-first shift, stop-bit check.
  always_comb begin
    phase_d   = phase_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    data_d    = data_q;
    ready_d   = 1'b0;
    ferr_d    = 1'b0;
    if (tick) begin
      case (state_q)
        RX_IDLE: begin
          phase_d   = '0;
          bit_cnt_d = '0;
        end
        RX_START: phase_d = (phase_q == PhaseMid) ? '0 : phase_q + 1'b1;
        RX_DATA: begin
          phase_d = phase_q + 1'b1;
          if (phase_q == PhaseLast) begin
            shift_d   = {rx_bit, shift_q[DATA_BITS-1:1]};
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
        RX_STOP: begin
          phase_d = phase_q + 1'b1;
          if (phase_q == PhaseLast) begin
            if (rx_bit) begin
              data_d  = shift_q;
              ready_d = 1'b1;
            end else begin
              ferr_d = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Gap counter counts high ticks in IDLE; end-of-packet fires once per burst on saturation.
  always_comb begin
    gap_d  = gap_q;
    seen_d = seen_q | ready_d | ferr_d;
    eop_d  = 1'b0;
    if (tick) begin
      if (!rx_bit) gap_d = '0;
      else if (state_q == RX_IDLE && gap_q != GapSat) gap_d = gap_q + 1'b1;
    end
    if (gap_d == GapSat && gap_q != GapSat && seen_q) begin
      eop_d  = 1'b1;
      seen_d = 1'b0;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RX_IDLE;
      sync_q    <= 2'b11;
      filt_q    <= 3'b111;
      phase_q   <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      ready_q   <= 1'b0;
      ferr_q    <= 1'b0;
      gap_q     <= GapSat;
      seen_q    <= 1'b0;
      eop_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      sync_q    <= sync_d;
      filt_q    <= filt_d;
      phase_q   <= phase_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      ready_q   <= ready_d;
      ferr_q    <= ferr_d;
      gap_q     <= gap_d;
      seen_q    <= seen_d;
      eop_q     <= eop_d;
    end
  end

  assign rx.RxD_data        = data_q;
  assign rx.RxD_data_ready  = ready_q;
  assign rx.RxD_frame_error = ferr_q;
  assign rx.RxD_idle        = (gap_q == GapSat);
  assign rx.RxD_endofpacket = eop_q;
endmodule

// File: tb/tb_async_receiver.sv
// Bench for async_receiver: vector table, randomized frames vs. byte-queue model, corner sequences.
module tb_async_receiver;
  localparam int BIT_CLK = 217;  // 25 MHz / 115200

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  async_receiver_if rx_if ();

  async_receiver dut (
    .clk  (clk),
    .rst_n(rst_n),
    .rx   (rx_if)
  );

  always #20 clk = ~clk;

  int nvec = 0;
  int nerr = 0;
  int rdy_cnt = 0, ferr_cnt = 0, eop_cnt = 0;
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];

  // Strobe monitor, sampled away from the active edge.
  always @(negedge clk) begin
    if (rx_if.RxD_data_ready) begin
      rdy_cnt++;
      got_q.push_back(rx_if.RxD_data);
    end
    if (rx_if.RxD_frame_error) ferr_cnt++;
    if (rx_if.RxD_endofpacket) eop_cnt++;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drives one 8N1 frame at bc clocks per bit, line left high afterwards.
  task automatic send_frame(input logic [7:0] d, input bit stop, input int bc);
    rx_if.RxD = 1'b0;
    wait_clk(bc);
    for (int i = 0; i < 8; i++) begin
      rx_if.RxD = d[i];
      wait_clk(bc);
    end
    rx_if.RxD = stop;
    wait_clk(bc);
    rx_if.RxD = 1'b1;
  endtask

  task automatic check_queue(input string tag);
    check({tag, " count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check($sformatf("%s byte%0d", tag, i), got_q[i], exp_q[i]);
  endtask

  typedef struct {
    logic [7:0] data;
    bit         stop;
    int         bc;
    int         exp_rdy;
    int         exp_ferr;
    logic [7:0] exp_data;
  } vec_t;

  vec_t tbl[8];
  int r0, f0, e0, nf, bc;
  logic [7:0] d;
  bit ok;

  initial begin
    tbl[0] = '{8'h55, 1'b1, 217, 1, 0, 8'h55};
    tbl[1] = '{8'h3C, 1'b0, 217, 0, 1, 8'h55};  // bad stop: data held
    tbl[2] = '{8'h81, 1'b1, 217, 1, 0, 8'h81};
    tbl[3] = '{8'hFF, 1'b1, 212, 1, 0, 8'hFF};  // sender +2.5%
    tbl[4] = '{8'h00, 1'b1, 212, 1, 0, 8'h00};
    tbl[5] = '{8'hFF, 1'b1, 223, 1, 0, 8'hFF};  // sender -2.5%
    tbl[6] = '{8'h00, 1'b1, 223, 1, 0, 8'h00};
    tbl[7] = '{8'hA5, 1'b0, 223, 0, 1, 8'h00};

    rx_if.RxD = 1'b1;
    wait_clk(5);
    check("reset data",  rx_if.RxD_data, 8'h00);
    check("reset ready", rx_if.RxD_data_ready, 0);
    check("reset ferr",  rx_if.RxD_frame_error, 0);
    check("reset idle",  rx_if.RxD_idle, 1);
    check("reset eop",   rx_if.RxD_endofpacket, 0);
    rst_n = 1'b1;
    wait_clk(BIT_CLK);

    // Table vectors
    for (int i = 0; i < 8; i++) begin
      r0 = rdy_cnt;
      f0 = ferr_cnt;
      send_frame(tbl[i].data, tbl[i].stop, tbl[i].bc);
      wait_clk(BIT_CLK);
      check($sformatf("tbl%0d ready", i), rdy_cnt - r0, tbl[i].exp_rdy);
      check($sformatf("tbl%0d ferr", i), ferr_cnt - f0, tbl[i].exp_ferr);
      check($sformatf("tbl%0d data", i), rx_if.RxD_data, tbl[i].exp_data);
    end

    // Randomized frames: model expects every good-stop byte in order, one error per bad stop.
    got_q.delete();
    exp_q.delete();
    f0 = ferr_cnt;
    nf = 0;
    for (int i = 0; i < 8; i++) begin
      d  = 8'($urandom);
      ok = ($urandom_range(0, 3) != 0);
      bc = $urandom_range(212, 223);
      if (ok) exp_q.push_back(d);
      else nf++;
      send_frame(d, ok, bc);
      wait_clk($urandom_range(1, 3) * BIT_CLK);
    end
    check_queue("rand");
    check("rand ferr", ferr_cnt - f0, nf);

    // Back-to-back bytes, then end-of-packet timing
    wait_clk(12 * BIT_CLK);
    got_q.delete();
    exp_q.delete();
    exp_q.push_back(8'hA3);
    exp_q.push_back(8'h0F);
    e0 = eop_cnt;
    send_frame(8'hA3, 1'b1, BIT_CLK);
    send_frame(8'h0F, 1'b1, BIT_CLK);
    wait_clk(8 * BIT_CLK);
    check("b2b early eop", eop_cnt - e0, 0);
    check("b2b early idle", rx_if.RxD_idle, 0);
    wait_clk(4 * BIT_CLK);
    check("b2b eop", eop_cnt - e0, 1);
    check("b2b idle", rx_if.RxD_idle, 1);
    check_queue("b2b");

    // 50-clk glitch on an idle line
    r0 = rdy_cnt; f0 = ferr_cnt; e0 = eop_cnt;
    rx_if.RxD = 1'b0;
    wait_clk(50);
    rx_if.RxD = 1'b1;
    wait_clk(12 * BIT_CLK);
    check("glitch ready", rdy_cnt - r0, 0);
    check("glitch ferr", ferr_cnt - f0, 0);
    check("glitch eop", eop_cnt - e0, 0);
    check("glitch idle", rx_if.RxD_idle, 1);

    // Reset asserted mid-byte (after bit 3)
    d = 8'h7E;
    rx_if.RxD = 1'b0;
    wait_clk(BIT_CLK);
    for (int i = 0; i < 4; i++) begin
      rx_if.RxD = d[i];
      wait_clk(BIT_CLK);
    end
    check("pre-reset idle", rx_if.RxD_idle, 0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async rst data",  rx_if.RxD_data, 8'h00);
    check("async rst ready", rx_if.RxD_data_ready, 0);
    check("async rst ferr",  rx_if.RxD_frame_error, 0);
    check("async rst idle",  rx_if.RxD_idle, 1);
    check("async rst eop",   rx_if.RxD_endofpacket, 0);
    rx_if.RxD = 1'b1;
    wait_clk(5);
    rst_n = 1'b1;
    r0 = rdy_cnt; f0 = ferr_cnt; e0 = eop_cnt;
    wait_clk(12 * BIT_CLK);
    check("post-rst stale ready", rdy_cnt - r0, 0);
    check("post-rst stale ferr", ferr_cnt - f0, 0);
    check("post-rst stale eop", eop_cnt - e0, 0);
    send_frame(8'h7E, 1'b1, BIT_CLK);
    wait_clk(BIT_CLK);
    check("post-rst ready", rdy_cnt - r0, 1);
    check("post-rst data", rx_if.RxD_data, 8'h7E);
    wait_clk(12 * BIT_CLK);
    check("post-rst eop", eop_cnt - e0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
